// File: rtl/rx_buffer_ctrl_if.sv
// Handshake bundle between rx_buffer_ctrl, the UART receiver, the dual-port RAM and the host.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface rx_buffer_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              rxDone;
  logic [7:0]        toMem;
  logic              memWrEn;
  logic [ADDR_W-1:0] memWrAddr;
  logic [7:0]        memWrData;
  logic [ADDR_W-1:0] memRdAddr;
  logic [7:0]        memRdData;
  logic              rdReq;
  logic              rdValid;
  logic [7:0]        rdData;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              clrOvf;

  modport slave (
    input  rxDone, toMem, memRdData, rdReq, clrOvf,
    output memWrEn, memWrAddr, memWrData, memRdAddr,
           rdValid, rdData, count, empty, full, overflow
  );

  modport master (
    output rxDone, toMem, memRdData, rdReq, clrOvf,
    input  memWrEn, memWrAddr, memWrData, memRdAddr,
           rdValid, rdData, count, empty, full, overflow
  );
endinterface

// File: rtl/rx_buffer_ctrl.sv
// Receive buffer controller: one RAM write per rxDone frame, circular FIFO, 3-cycle host read.
// Optional feature macro RXCTRL_OVERWRITE_EN: when full, a new byte overwrites the oldest one.
module rx_buffer_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic           baudClk,
  input  logic           reset,
  rx_buffer_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_OUT  = 2'd2
  } rd_state_t;

  rd_state_t         state_r;
  logic              rx_done_prev_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              mem_wr_en_r;
  logic [ADDR_W-1:0] mem_wr_addr_r;
  logic [7:0]        mem_wr_data_r;
  logic              rd_valid_r;
  logic [7:0]        rd_data_r;
  logic              overflow_r;

  logic              empty_s;
  logic              full_s;
  logic              wr_event_s;
  logic              rd_accept_s;
  logic              ovf_s;
  logic              do_write_s;
  logic              rd_adv_s;
  logic              count_inc_s;

  // Event decode: frame edge, read acceptance, overflow and the resulting pointer moves.
  always_comb begin
    empty_s     = (count_r == {(ADDR_W+1){1'b0}});
    full_s      = (count_r == DEPTH_V);
    wr_event_s  = bus.rxDone & ~rx_done_prev_r;
    rd_accept_s = (state_r == IDLE) & bus.rdReq & ~empty_s;
    ovf_s       = wr_event_s & full_s & ~rd_accept_s;
    // An overwrite keeps count at DEPTH, so only a non-overflow write grows the buffer.
    count_inc_s = wr_event_s & ~ovf_s;
`ifdef RXCTRL_OVERWRITE_EN
    do_write_s  = wr_event_s;
    rd_adv_s    = rd_accept_s | ovf_s;
`else
    do_write_s  = wr_event_s & ~ovf_s;
    rd_adv_s    = rd_accept_s;
`endif
  end

  // Write path, pointers, occupancy and sticky overflow.
  always_ff @(posedge baudClk) begin
    if (reset) begin
      rx_done_prev_r <= 1'b0;
      wr_ptr_r       <= {ADDR_W{1'b0}};
      rd_ptr_r       <= {ADDR_W{1'b0}};
      count_r        <= {(ADDR_W+1){1'b0}};
      mem_wr_en_r    <= 1'b0;
      mem_wr_addr_r  <= {ADDR_W{1'b0}};
      mem_wr_data_r  <= 8'h00;
      overflow_r     <= 1'b0;
    end else begin
      rx_done_prev_r <= bus.rxDone;
      mem_wr_en_r    <= do_write_s;
      if (do_write_s) begin
        mem_wr_addr_r <= wr_ptr_r;
        mem_wr_data_r <= bus.toMem;
        wr_ptr_r      <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({count_inc_s, rd_accept_s})
        2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clrOvf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Host read FSM: accept in IDLE, capture RAM data in RD_WAIT, pulse rdValid in RD_OUT.
  always_ff @(posedge baudClk) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          rd_valid_r <= 1'b0;
          if (rd_accept_s) begin
            state_r <= RD_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          rd_data_r  <= bus.memRdData;
          rd_valid_r <= 1'b1;
          state_r    <= RD_OUT;
        end
        RD_OUT: begin
          rd_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          rd_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.memWrEn   = mem_wr_en_r;
  assign bus.memWrAddr = mem_wr_addr_r;
  assign bus.memWrData = mem_wr_data_r;
  assign bus.memRdAddr = rd_ptr_r;
  assign bus.rdValid   = rd_valid_r;
  assign bus.rdData    = rd_data_r;
  assign bus.count     = count_r;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl with a RAM model and a write/read scoreboard.
// Expectations follow RXCTRL_OVERWRITE_EN when that macro is defined.
module tb_rx_buffer_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rx_buffer_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  rx_buffer_ctrl #(.ADDR_W(ADDR_W)) dut (.baudClk(clk), .reset(reset), .bus(bus));

  logic [7:0]  ram [DEPTH];
  logic [11:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  fifo_q [$];
  logic [3:0]  wr_addr_m;
  logic        ovf_m;
  logic [11:0] wr_exp;
  logic [7:0]  rd_exp;
  logic [12:0] pulses;
  int vectors = 0;
  int miscompares = 0;

  // Synchronous dual-port RAM, 1-cycle read latency, write-through on same address
  always @(posedge clk) begin
    if (bus.memWrEn === 1'b1) ram[bus.memWrAddr] <= bus.memWrData;
    bus.memRdData <= (bus.memWrEn === 1'b1 && bus.memWrAddr == bus.memRdAddr) ?
                     bus.memWrData : ram[bus.memRdAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe and read pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset && bus.memWrEn === 1'b1) begin
      check("wr_pulse_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", 32'(bus.memWrAddr), 32'(wr_exp[11:8]));
        check("wr_data", 32'(bus.memWrData), 32'(wr_exp[7:0]));
      end
    end
    if (!reset && bus.rdValid === 1'b1) begin
      check("rd_pulse_expected", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) begin
        rd_exp = rd_q.pop_front();
        check("rd_data", 32'(bus.rdData), 32'(rd_exp));
      end
    end
  end

  function automatic bit model_write(input logic [7:0] d);
    if (fifo_q.size() < DEPTH) begin
      wr_q.push_back({wr_addr_m, d});
      wr_addr_m = wr_addr_m + 4'd1;
      fifo_q.push_back(d);
      return 1'b1;
    end
    ovf_m = 1'b1;
`ifdef RXCTRL_OVERWRITE_EN
    wr_q.push_back({wr_addr_m, d});
    wr_addr_m = wr_addr_m + 4'd1;
    void'(fifo_q.pop_front());
    fifo_q.push_back(d);
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear;
    wr_q.delete();
    rd_q.delete();
    fifo_q.delete();
    wr_addr_m = 4'd0;
    ovf_m = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(fifo_q.size()));
    check({tag, "_empty"}, 32'(bus.empty), 32'(fifo_q.size() == 0));
    check({tag, "_full"}, 32'(bus.full), 32'(fifo_q.size() == DEPTH));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(ovf_m));
  endtask

  task automatic frame(input logic [7:0] d, input int hold);
    bit we;
    bus.toMem = d;
    bus.rxDone = 1'b1;
    we = model_write(d);
    tick;
    check("wr_latency", 32'(bus.memWrEn), 32'(we));
    check("count_after_wr", 32'(bus.count), 32'(fifo_q.size()));
    repeat (hold - 1) tick;
    bus.rxDone = 1'b0;
    bus.toMem = 8'h00;
    tick;
    tick;
  endtask

  task automatic read_one;
    bus.rdReq = 1'b1;
    rd_q.push_back(fifo_q.pop_front());
    tick;
    bus.rdReq = 1'b0;
    tick;
    check("rd_latency", 32'(bus.rdValid), 32'd1);
    tick;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && (wr_q.size() + rd_q.size()) > 0; i++) tick;
    check("drain", 32'(wr_q.size() + rd_q.size()), 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.rxDone = 1'b0;
    bus.rdReq = 1'b0;
    bus.clrOvf = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    model_clear();
    tick;
  endtask

  initial begin
    bus.rxDone = 1'b0;
    bus.toMem = 8'h00;
    bus.rdReq = 1'b0;
    bus.clrOvf = 1'b0;
    model_clear();
    repeat (2) tick;
    check("rst_memWrEn", 32'(bus.memWrEn), 32'd0);
    check("rst_memWrAddr", 32'(bus.memWrAddr), 32'd0);
    check("rst_memWrData", 32'(bus.memWrData), 32'd0);
    check("rst_memRdAddr", 32'(bus.memRdAddr), 32'd0);
    check("rst_rdValid", 32'(bus.rdValid), 32'd0);
    check("rst_rdData", 32'(bus.rdData), 32'd0);
    check_status("rst");
    reset = 1'b0;
    tick;

    // Single long frame: one write only
    frame(8'hA5, 10);
    check_status("single");
    read_one();
    drain();
    check_status("single_rd");

    // Three frames, then rdReq held high
    frame(8'h11, 4);
    frame(8'h22, 4);
    frame(8'h33, 4);
    bus.rdReq = 1'b1;
    repeat (3) rd_q.push_back(fifo_q.pop_front());
    pulses = 13'd0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      pulses[k] = bus.rdValid;
    end
    bus.rdReq = 1'b0;
    check("rd_spacing", 32'(pulses), 32'h124);
    drain();
    check_status("readback");

    // Fill from a fresh reset, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) frame(8'(i), 2);
    check_status("filled");
    frame(8'hFF, 3);
    drain();
    check_status("overflow");
    repeat (DEPTH) read_one();
    drain();
    check_status("ovf_drained");
    bus.clrOvf = 1'b1;
    tick;
    bus.clrOvf = 1'b0;
    ovf_m = 1'b0;
    check_status("clr_ovf");

    // Refill across the pointer wrap, then read and write in the same cycle while full
    for (int i = 0; i < DEPTH; i++) frame(8'h40 + 8'(i), 2);
    check_status("refill");
    bus.rdReq = 1'b1;
    bus.rxDone = 1'b1;
    bus.toMem = 8'h99;
    rd_q.push_back(fifo_q.pop_front());
    void'(model_write(8'h99));
    tick;
    bus.rdReq = 1'b0;
    check("simul_wr", 32'(bus.memWrEn), 32'd1);
    check_status("simul");
    tick;
    bus.rxDone = 1'b0;
    drain();
    repeat (DEPTH) read_one();
    drain();
    check_status("simul_drained");

    // Reset while the read FSM is in RD_WAIT
    frame(8'h77, 2);
    bus.rdReq = 1'b1;
    tick;
    bus.rdReq = 1'b0;
    reset = 1'b1;
    tick;
    model_clear();
    check("rst_rd_valid", 32'(bus.rdValid), 32'd0);
    check_status("rst_mid_read");

    // rxDone already high when reset releases counts as a new frame
    bus.rxDone = 1'b1;
    bus.toMem = 8'h5A;
    tick;
    reset = 1'b0;
    void'(model_write(8'h5A));
    tick;
    check("rel_wr", 32'(bus.memWrEn), 32'd1);
    check("rel_rdValid", 32'(bus.rdValid), 32'd0);
    bus.rxDone = 1'b0;
    repeat (3) tick;
    drain();
    check_status("release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rx_buffer_ctrl.md
# rx_buffer_ctrl

Receive-side buffer controller sitting between the UART `Receiver` and a dual-port synchronous RAM. Converts each `rxDone` frame indication into exactly one RAM write and manages the RAM as a circular FIFO. Serves bytes to a host over a request/valid read handshake. Reports occupancy and overflow, all in the `baudClk` domain.

## Interface
- `ADDR_W`, 4, RAM address width; buffer depth DEPTH = 2^ADDR_W bytes
- `baudClk`  in  1  sole clock, same clock as `Receiver`
- `reset`  in  1  synchronous, active-high reset
- `rxDone`  in  1  `Receiver` frame-done level; high for several cycles per frame
- `toMem`  in  8  `Receiver` data byte, valid while `rxDone` is high
- `memWrEn`  out  1  RAM write strobe, one-cycle pulse per stored byte
- `memWrAddr`  out  ADDR_W  RAM write address
- `memWrData`  out  8  RAM write data
- `memRdAddr`  out  ADDR_W  RAM read address; combinationally equal to rdPtr
- `memRdData`  in  8  RAM read data, registered, 1-cycle read latency
- `rdReq`  in  1  host read request, level-sampled
- `rdValid`  out  1  one-cycle pulse marking `rdData` valid
- `rdData`  out  8  byte returned to host
- `count`  out  ADDR_W+1  bytes currently stored, 0..DEPTH
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky overflow flag
- `clrOvf`  in  1  clears `overflow`

## Operation
- **Frame detect:** `rxDonePrev` register. A write event occurs in cycle t when `rxDone=1 && rxDonePrev=0`. `toMem` is sampled in that cycle. Only one event per `rxDone` high period, however long it lasts.
- **Write path:** on an accepted event, registered outputs `memWrEn=1`, `memWrAddr=wrPtr`, `memWrData=toMem` in cycle t+1, then `memWrEn=0`. wrPtr increments modulo DEPTH at the end of t.
- **Read FSM:**
  - IDLE: if `rdReq && !empty`, accept the read. rdPtr increments modulo DEPTH at the end of the cycle. Go to RD_WAIT.
  - RD_WAIT: the RAM presents data; capture `memRdData` into `rdData`. Go to RD_OUT.
  - RD_OUT: `rdValid=1`. Return to IDLE.
  - `rdReq` is ignored outside IDLE and when `empty=1`.
- **Count:**
  - +1 on an accepted write alone.
  - -1 on an accepted read alone.
  - Unchanged when both occur in the same cycle.
  - `empty`/`full` are decoded combinationally from `count`.
- **Full buffer:**
  - A write event while `count==DEPTH` with no read accepted in the same cycle is an overflow. Handling is set by `RXCTRL_OVERWRITE_EN` (see Configuration).
  - If a read is accepted in the same cycle, the write proceeds normally and no overflow is flagged.
- **Overflow flag:** set on an overflow event, cleared by `clrOvf`. Set wins if both occur in the same cycle.
- **Pointer wrap:** wrPtr/rdPtr are ADDR_W bits and wrap naturally. DEPTH-1 → 0 requires no special case.

## Timing
- Reset values (synchronous, applied at the next `baudClk` edge):
  - `memWrEn=0`, `memWrAddr=0`, `memWrData=0`, `memRdAddr=0`
  - `rdValid=0`, `rdData=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`
  - FSM=IDLE, pointers=0, `rxDonePrev=0`
- Reset mid-read aborts the read: no `rdValid` pulse. Buffer contents are logically discarded.
- Write latency: `rxDone` rising in cycle t → `memWrEn` high in t+1. `count` is updated at t+1.
- Read latency: `rdReq` accepted in t → `rdValid` pulse in t+2 → next acceptance possible in t+3. Peak rate is one byte per 3 cycles, far above the UART byte rate.
- `rxDone` asserted in the same cycle `reset` is released is seen as a rising edge.
- Write and read paths are independent; simultaneous write and read in one cycle are legal.

## Configuration
- `RXCTRL_OVERWRITE_EN` **defined:** on overflow, the new byte is written at wrPtr. wrPtr and rdPtr both advance, so the oldest byte is discarded. `count` stays DEPTH. `overflow` is set.
- `RXCTRL_OVERWRITE_EN` **undefined (default):** on overflow, the new byte is dropped. No `memWrEn` is issued, pointers and `count` are unchanged, and `overflow` is set.
- If a read is in RD_WAIT/RD_OUT during an overwrite, it completes with the byte already addressed.

## Test plan
- **Single frame:** reset, then `rxDone` high 10 cycles with `toMem=0xA5`. Expect exactly one `memWrEn` pulse at addr 0, data 0xA5, `count=1`, `empty=0`.
- **Read-back:** after 3 frames 0x11, 0x22, 0x33, hold `rdReq` high. Expect `rdValid` pulses 3 cycles apart with 0x11, 0x22, 0x33, then `count=0`, `empty=1`, and no further pulses.
- **Wrap:** with ADDR_W=2, write 4 bytes, read 2, write 2. Expect write addresses 0,1,2,3,0,1 and read order preserved.
- **Overflow, default build:** fill 16 bytes 0x00..0x0F, send 0xFF. Expect no `memWrEn`, `full=1`, `overflow=1`, reads return 0x00..0x0F. Then pulse `clrOvf` and expect `overflow=0`.
- **Overflow with `RXCTRL_OVERWRITE_EN`:** same stimulus. Expect write of 0xFF at addr 0, first read returns 0x01, last read returns 0xFF.
- **Simultaneous and reset:**
  - When full, accept a read in the same cycle as an `rxDone` rise. Expect the write to occur, `count` stays 16, `overflow=0`.
  - Assert `reset` in RD_WAIT. Expect no `rdValid`, with `count=0` and `empty=1` next cycle.
